// File: rtl/ysyx_24100006_wbu_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100006_wbu_if
//  Brief    : Write-back unit bus: ALU/LSU result handshakes, scoreboard
//             allocation, hazard queries and the GPR write port.
//  Revision : 1.0  initial release
// ============================================================================
interface ysyx_24100006_wbu_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    // ALU result channel
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    // LSU load channel
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_rdata;
    logic [1:0]            lsu_offset;
    logic [1:0]            lsu_size;
    logic                  lsu_unsigned;
    // scoreboard allocation and hazard queries
    logic                  alloc_valid;
    logic [ADDR_WIDTH-1:0] alloc_rd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;
    // GPR write port
    logic                  gpr_wen;
    logic [ADDR_WIDTH-1:0] gpr_waddr;
    logic [DATA_WIDTH-1:0] gpr_wdata;
    logic                  retire;

    // write-back unit side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_rdata, lsu_offset, lsu_size, lsu_unsigned,
        input  alloc_valid, alloc_rd, rs1, rs2,
        output alu_ready, lsu_ready, rs1_busy, rs2_busy,
        output gpr_wen, gpr_waddr, gpr_wdata, retire
    );

    // pipeline / environment side
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_rdata, lsu_offset, lsu_size, lsu_unsigned,
        output alloc_valid, alloc_rd, rs1, rs2,
        input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
        input  gpr_wen, gpr_waddr, gpr_wdata, retire
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24100006_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100006_wbu
//  Brief    : Write-back unit. Arbitrates ALU results and LSU loads, aligns
//             and extends load data, registers one GPR write per cycle and
//             tracks outstanding writes for RAW hazard detection.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_24100006_wbu #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  wire                      clk,
    input  wire                      rst_n,
    ysyx_24100006_wbu_if.slave       bus
);
    localparam int NREG = 1 << ADDR_WIDTH;

    // source that won the most recent contended cycle
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    src_e                  r_last;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_retire;
    logic [NREG-1:0]       r_pend;

    logic                  w_alu_ready;
    logic                  w_lsu_ready;
    logic                  w_alu_fire;
    logic                  w_lsu_fire;
    logic                  w_fire;
    logic                  w_contend;
    logic [ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_data;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [NREG-1:0]       w_set;
    logic [NREG-1:0]       w_clr;

    // Round-robin grant: when both sources are valid exactly one ready is high,
    // so at most one handshake happens per cycle.
    assign w_alu_ready = !bus.lsu_valid || (r_last == SRC_LSU);
    assign w_lsu_ready = !bus.alu_valid || (r_last == SRC_ALU);
    assign w_alu_fire  = bus.alu_valid && w_alu_ready;
    assign w_lsu_fire  = bus.lsu_valid && w_lsu_ready;
    assign w_fire      = w_alu_fire || w_lsu_fire;
    assign w_contend   = bus.alu_valid && bus.lsu_valid;

    assign bus.alu_ready = w_alu_ready;
    assign bus.lsu_ready = w_lsu_ready;

    // Load alignment and extension; half ignores offset[0], word ignores offset.
    always_comb begin
        w_byte = 8'h00;
        w_load = '0;
        case (bus.lsu_offset)
            2'd0:    w_byte = bus.lsu_rdata[7:0];
            2'd1:    w_byte = bus.lsu_rdata[15:8];
            2'd2:    w_byte = bus.lsu_rdata[23:16];
            default: w_byte = bus.lsu_rdata[31:24];
        endcase
        w_half = bus.lsu_offset[1] ? bus.lsu_rdata[31:16] : bus.lsu_rdata[15:0];
        case (bus.lsu_size)
            2'b00:   w_load = {{(DATA_WIDTH-8){!bus.lsu_unsigned && w_byte[7]}}, w_byte};
            2'b01:   w_load = {{(DATA_WIDTH-16){!bus.lsu_unsigned && w_half[15]}}, w_half};
            default: w_load = bus.lsu_rdata;
        endcase
    end

    assign w_rd   = w_alu_fire ? bus.alu_rd   : bus.lsu_rd;
    assign w_data = w_alu_fire ? bus.alu_data : w_load;

    // Grant history only moves when both sources competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SRC_ALU;
        end else if (w_contend) begin
            r_last <= w_lsu_fire ? SRC_LSU : SRC_ALU;
        end
    end

    // Output write register: never stalls; rd=0 retires without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen    <= 1'b0;
            r_retire <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_wen    <= w_fire && (w_rd != '0);
            r_retire <= w_fire;
            if (w_fire) begin
                r_waddr <= w_rd;
                r_wdata <= w_data;
            end
        end
    end

    // Pending set/clear masks; x0 is never tracked.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.alloc_valid && (bus.alloc_rd != '0)) begin
            w_set[bus.alloc_rd] = 1'b1;
        end
        if (r_wen) begin
            w_clr[r_waddr] = 1'b1;
        end
    end

    // Scoreboard: a new allocation beats the retiring write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    assign bus.rs1_busy  = (bus.rs1 != '0) && r_pend[bus.rs1];
    assign bus.rs2_busy  = (bus.rs2 != '0) && r_pend[bus.rs2];
    assign bus.gpr_wen   = r_wen;
    assign bus.gpr_waddr = r_waddr;
    assign bus.gpr_wdata = r_wdata;
    assign bus.retire    = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24100006_wbu
//  Brief    : Directed self-checking bench for the write-back unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24100006_wbu;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    ysyx_24100006_wbu_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    ysyx_24100006_wbu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past the next rising edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // load extraction vectors: size, offset, unsigned, expected
    logic [1:0]  v_size [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0]  v_off  [8] = '{2'd1,  2'd1,  2'd2,  2'd0,  2'd3,  2'd3,  2'd3,  2'd1};
    logic        v_uns  [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    logic [31:0] v_exp  [8] = '{32'hFFFFFF80, 32'h00000080, 32'h000012F4, 32'hFFFF80AB,
                                32'h12F480AB, 32'h00000012, 32'h000012F4, 32'h12F480AB};

    initial begin
        rst_n            = 1'b0;
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = '0;
        bus.alu_data     = '0;
        bus.lsu_valid    = 1'b0;
        bus.lsu_rd       = '0;
        bus.lsu_rdata    = '0;
        bus.lsu_offset   = '0;
        bus.lsu_size     = '0;
        bus.lsu_unsigned = 1'b0;
        bus.alloc_valid  = 1'b0;
        bus.alloc_rd     = '0;
        bus.rs1          = '0;
        bus.rs2          = '0;

        // reset state
        step();
        check("rst_wen",    32'(bus.gpr_wen),   32'h0);
        check("rst_waddr",  32'(bus.gpr_waddr), 32'h0);
        check("rst_wdata",  bus.gpr_wdata,      32'h0);
        check("rst_retire", 32'(bus.retire),    32'h0);
        check("rst_alu_rdy", 32'(bus.alu_ready), 32'h1);
        check("rst_lsu_rdy", 32'(bus.lsu_ready), 32'h1);
        rst_n = 1'b1;
        step();

        // single ALU result
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd5;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        check("alu_ready_solo", 32'(bus.alu_ready), 32'h1);
        step();
        bus.alu_valid = 1'b0;
        check("alu_wen",    32'(bus.gpr_wen),   32'h1);
        check("alu_waddr",  32'(bus.gpr_waddr), 32'h5);
        check("alu_wdata",  bus.gpr_wdata,      32'hDEADBEEF);
        check("alu_retire", 32'(bus.retire),    32'h1);
        step();
        check("alu_wen_idle",    32'(bus.gpr_wen), 32'h0);
        check("alu_retire_idle", 32'(bus.retire),  32'h0);

        // load extraction
        bus.lsu_rd    = 4'd4;
        bus.lsu_rdata = 32'h12F480AB;
        for (int i = 0; i < 8; i++) begin
            bus.lsu_valid    = 1'b1;
            bus.lsu_size     = v_size[i];
            bus.lsu_offset   = v_off[i];
            bus.lsu_unsigned = v_uns[i];
            step();
            bus.lsu_valid = 1'b0;
            check($sformatf("load_%0d", i), bus.gpr_wdata, v_exp[i]);
        end
        check("load_waddr", 32'(bus.gpr_waddr), 32'h4);
        step();

        // arbitration from a fresh reset: LSU, ALU, LSU
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 4'd1;
        bus.alu_data   = 32'h22222222;
        bus.lsu_valid  = 1'b1;
        bus.lsu_rd     = 4'd2;
        bus.lsu_rdata  = 32'h11111111;
        bus.lsu_size   = 2'b10;
        #1;
        check("arb0_alu_rdy", 32'(bus.alu_ready), 32'h0);
        check("arb0_lsu_rdy", 32'(bus.lsu_ready), 32'h1);
        step();
        check("arb1_waddr",   32'(bus.gpr_waddr), 32'h2);
        check("arb1_wdata",   bus.gpr_wdata,      32'h11111111);
        check("arb1_alu_rdy", 32'(bus.alu_ready), 32'h1);
        check("arb1_lsu_rdy", 32'(bus.lsu_ready), 32'h0);
        step();
        check("arb2_waddr",   32'(bus.gpr_waddr), 32'h1);
        check("arb2_wdata",   bus.gpr_wdata,      32'h22222222);
        check("arb2_alu_rdy", 32'(bus.alu_ready), 32'h0);
        check("arb2_lsu_rdy", 32'(bus.lsu_ready), 32'h1);
        step();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        check("arb3_waddr", 32'(bus.gpr_waddr), 32'h2);
        check("arb3_wen",   32'(bus.gpr_wen),   32'h1);
        step();

        // scoreboard: allocate 7, write 7
        bus.rs1         = 4'd7;
        bus.rs2         = 4'd7;
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 4'd7;
        #1;
        check("sb_busy_before", 32'(bus.rs1_busy), 32'h0);
        step();
        bus.alloc_valid = 1'b0;
        check("sb_busy_rs1", 32'(bus.rs1_busy), 32'h1);
        check("sb_busy_rs2", 32'(bus.rs2_busy), 32'h1);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd7;
        bus.alu_data  = 32'h00000007;
        step();
        bus.alu_valid = 1'b0;
        check("sb_wen_7",       32'(bus.gpr_wen),  32'h1);
        check("sb_busy_in_wen", 32'(bus.rs1_busy), 32'h1);
        step();
        check("sb_busy_after", 32'(bus.rs1_busy), 32'h0);

        // scoreboard: re-allocation on the same edge as the write wins
        bus.alloc_valid = 1'b1;
        step();
        bus.alloc_valid = 1'b0;
        bus.alu_valid   = 1'b1;
        step();
        bus.alu_valid   = 1'b0;
        bus.alloc_valid = 1'b1;
        check("sb2_wen", 32'(bus.gpr_wen), 32'h1);
        step();
        bus.alloc_valid = 1'b0;
        check("sb2_set_wins", 32'(bus.rs1_busy), 32'h1);
        bus.alu_valid = 1'b1;
        step();
        bus.alu_valid = 1'b0;
        step();
        check("sb2_cleared", 32'(bus.rs1_busy), 32'h0);

        // rd = 0: retire without write, alloc of x0 ignored
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 4'd0;
        bus.alu_data    = 32'h00000055;
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 4'd0;
        bus.rs1         = 4'd0;
        step();
        bus.alu_valid   = 1'b0;
        bus.alloc_valid = 1'b0;
        check("x0_wen",    32'(bus.gpr_wen),   32'h0);
        check("x0_retire", 32'(bus.retire),    32'h1);
        check("x0_waddr",  32'(bus.gpr_waddr), 32'h0);
        check("x0_wdata",  bus.gpr_wdata,      32'h00000055);
        check("x0_busy",   32'(bus.rs1_busy),  32'h0);
        step();

        // asynchronous reset while a write is in flight
        bus.rs1         = 4'd3;
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 4'd3;
        step();
        bus.alloc_valid = 1'b0;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 4'd3;
        bus.alu_data    = 32'hCAFEF00D;
        step();
        bus.alu_valid = 1'b0;
        check("ar_pre_wen",  32'(bus.gpr_wen),  32'h1);
        check("ar_pre_busy", 32'(bus.rs1_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_wen",    32'(bus.gpr_wen),   32'h0);
        check("ar_retire", 32'(bus.retire),    32'h0);
        check("ar_busy",   32'(bus.rs1_busy),  32'h0);
        check("ar_waddr",  32'(bus.gpr_waddr), 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
